// File: rtl/multicycle_comparator.sv
// Chunk-serial magnitude compare, MSB chunk first, stopping at the first differing chunk.
// Result is held until the next done pulse; done arrives chunks_used cycles after the start edge.
module multicycle_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          is_signed,
    output logic                          busy,
    output logic                          done,
    output logic                          agb,
    output logic                          eq,
    output logic                          alb,
    output logic [$clog2(WIDTH/CHUNK):0]  chunks_used
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CUW    = $clog2(NCHUNK) + 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             done_q, done_d;
    logic             agb_q, agb_d;
    logic             eq_q, eq_d;
    logic             alb_q, alb_d;
    logic [CUW-1:0]   cu_q, cu_d;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [WIDTH-1:0] sign_flip;

    assign a_chunk   = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk   = b_q[int'(idx_q) * CHUNK +: CHUNK];
    // Offset binary: flipping both MSBs makes an unsigned compare follow signed order.
    assign sign_flip = is_signed ? MSB_MASK : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        agb_d   = agb_q;
        eq_d    = eq_q;
        alb_d   = alb_q;
        cu_d    = cu_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a ^ sign_flip;
                    b_d     = b ^ sign_flip;
                    idx_d   = IDX_TOP;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_chunk != b_chunk) begin
                    agb_d   = (a_chunk > b_chunk);
                    alb_d   = (a_chunk < b_chunk);
                    eq_d    = 1'b0;
                    cu_d    = CUW'(NCHUNK) - CUW'(idx_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    agb_d   = 1'b0;
                    alb_d   = 1'b0;
                    eq_d    = 1'b1;
                    cu_d    = CUW'(NCHUNK);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            agb_q   <= 1'b0;
            eq_q    <= 1'b1;
            alb_q   <= 1'b0;
            cu_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            agb_q   <= agb_d;
            eq_q    <= eq_d;
            alb_q   <= alb_d;
            cu_q    <= cu_d;
        end
    end

    assign busy        = (state_q == COMPARE);
    assign done        = done_q;
    assign agb         = agb_q;
    assign eq          = eq_q;
    assign alb         = alb_q;
    assign chunks_used = cu_q;

endmodule

// File: tb/tb_multicycle_comparator.sv
// Directed bench for multicycle_comparator at WIDTH=16, CHUNK=4.
module tb_multicycle_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic        agb;
    logic        eq;
    logic        alb;
    logic [2:0]  chunks_used;

    int total  = 0;
    int passed = 0;

    multicycle_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .agb         (agb),
        .eq          (eq),
        .alb         (alb),
        .chunks_used (chunks_used)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until done, or 0 if it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic s, input logic eagb, input logic eeq, input logic ealb,
                       input int ecu);
        int lat;
        a = av; b = bv; is_signed = s; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(ecu));
        chk({tag, "_flags"}, {29'd0, agb, eq, alb}, {29'd0, eagb, eeq, ealb});
        chk({tag, "_chunks"}, 32'(chunks_used), 32'(ecu));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_onepulse"}, 32'(done), 32'd0);
        chk({tag, "_held"}, {26'd0, agb, eq, alb, chunks_used}, {26'd0, eagb, eeq, ealb, 3'(ecu)});
    endtask

    logic [15:0] pa [2];
    logic [15:0] pb [2];
    logic [2:0]  pflags [2];
    int          pcu [2];
    int          lat;
    int          j;
    int          extra_done;

    initial begin
        pa[0] = 16'h8000; pb[0] = 16'h7FFF; pflags[0] = 3'b100; pcu[0] = 1;
        pa[1] = 16'h1234; pb[1] = 16'h1234; pflags[1] = 3'b010; pcu[1] = 4;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        step();
        step();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_flags", {29'd0, agb, eq, alb}, 32'b010);
        chk("rst_chunks", 32'(chunks_used), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_flags", {29'd0, agb, eq, alb, busy}, 32'b0100);

        run("eq_u",        16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        run("early_u",     16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run("early_s",     16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        run("last_u",      16'h1235, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        run("last_s",      16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        run("neg_vs_pos",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        run("eq_s",        16'h8001, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 4);
        run("mid_u",       16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        // Start while busy must be ignored and must not disturb the captured operands.
        a = 16'h0001; b = 16'h0002; is_signed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ign_done1", 32'(done), 32'd0);
        step();
        a = 16'hFFFF; b = 16'h0000; is_signed = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_busy3", 32'(busy), 32'd1);
        chk("ign_done3", 32'(done), 32'd0);
        step();
        chk("ign_done4", 32'(done), 32'd1);
        chk("ign_flags", {29'd0, agb, eq, alb}, 32'b001);
        chk("ign_chunks", 32'(chunks_used), 32'd4);
        extra_done = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done) extra_done++;
        end
        chk("ign_no_second_done", 32'(extra_done), 32'd0);
        chk("ign_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high; operands changed while busy.
        a = pa[0]; b = pb[0]; is_signed = 1'b0; start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            j = i % 2;
            chk("b2b_busy", 32'(busy), 32'd1);
            a = pa[(i + 1) % 2];
            b = pb[(i + 1) % 2];
            wait_done(lat);
            chk("b2b_latency", 32'(lat), 32'(pcu[j]));
            chk("b2b_flags", {29'd0, agb, eq, alb}, {29'd0, pflags[j]});
            chk("b2b_chunks", 32'(chunks_used), 32'(pcu[j]));
            if (i < 3) step();
        end
        start = 1'b0;
        step();
        chk("b2b_drain_busy", 32'(busy), 32'd0);
        chk("b2b_drain_done", 32'(done), 32'd0);

        // Reset in the middle of an equal-operand compare.
        a = 16'h1234; b = 16'h1234; is_signed = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_flags", {29'd0, agb, eq, alb}, 32'b010);
        chk("mid_rst_chunks", 32'(chunks_used), 32'd0);
        extra_done = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done || busy) extra_done++;
        end
        chk("mid_rst_quiet", 32'(extra_done), 32'd0);
        run("post_rst", 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
